out_buf: RTL and testbench



---
 rtl/out_buf_if.sv | 27 ++
 rtl/out_buf.sv | 108 ++++++++++
 tb/tb_out_buf.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/out_buf_if.sv
// Stream-side signals of the output result buffer: sequencer write port and
// destination read port.
interface out_buf_if #(
   parameter int DW = 32,
   parameter int AW = 12,
   parameter int RW = 4
);
   logic          outr;
   logic [RW-1:0] ra;
   logic [AW-1:0] oa;
   logic          update;
   logic [DW-1:0] od_data;
   logic          dst_v;
   logic [AW-1:0] dst_a;
   logic          dst_ready;
   logic [DW-1:0] dst_data;

   modport master (
      output outr, ra, oa, update, od_data, dst_v, dst_a, dst_ready,
      input  dst_data
   );

   modport slave (
      input  outr, ra, oa, update, od_data, dst_v, dst_a, dst_ready,
      output dst_data
   );
endinterface

// File: rtl/out_buf.sv
// Output result buffer: two-stage write pipeline into a word memory, 1-cycle
// read port with write-first bypass, word counter and completion FSM.
// Define OUT_RELU_EN to clamp negative results to zero before storage.
module out_buf #(
   parameter int DW = 32,
   parameter int AW = 12,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_init,
   out_buf_if.slave      bus,
   output logic [AW:0]   wcnt,
   output logic          out_done
);

   localparam logic [AW:0] WCNT_MAX = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] WCNT_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      DONE
   } state_t;

   state_t        state;
   logic          w_v;
   logic [AW-1:0] w_a;
   logic [DW-1:0] wr_data;
   logic          bypass;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_comb begin
      wr_data = bus.od_data;
`ifdef OUT_RELU_EN
      if (bus.od_data[DW-1]) wr_data = '0;
`endif
   end

   assign bypass = w_v && (w_a == bus.dst_a);

   // W0: align the write address with od_data, which arrives one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_v <= 1'b0;
         w_a <= '0;
      end else begin
         w_v <= bus.outr;
         w_a <= bus.oa;
      end
   end

   // Memory is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (w_v) mem[w_a] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.dst_data <= '0;
      end else if (bus.dst_v) begin
         bus.dst_data <= bypass ? wr_data : mem[bus.dst_a];
      end
   end

   // A write landing with s_init belongs to the new batch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= '0;
      end else if (s_init) begin
         wcnt <= w_v ? WCNT_ONE : '0;
      end else if (w_v && (wcnt != WCNT_MAX)) begin
         wcnt <= wcnt + WCNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         out_done <= 1'b0;
      end else if (s_init) begin
         state    <= IDLE;
         out_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.update) state <= DRAIN;
            end
            DRAIN: begin
               state    <= DONE;
               out_done <= 1'b1;
            end
            DONE: begin
               if (bus.dst_v) begin
                  state    <= IDLE;
                  out_done <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               out_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_buf.sv
// Directed self-checking bench for out_buf; expected values are hand-computed.
module tb_out_buf;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int RW = 4;

   logic          clk;
   logic          rst_n;
   logic          s_init;
   logic [AW:0]   wcnt;
   logic          out_done;
   logic [DW-1:0] relu_exp;

   int errors;
   int checks;

   out_buf_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

   out_buf #(.DW(DW), .AW(AW), .RW(RW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_init   (s_init),
      .bus      (bus.slave),
      .wcnt     (wcnt),
      .out_done (out_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #12;
      checks++;
      if (wcnt !== 13'd0) begin errors++; $display("FAIL reset_wcnt got=%h exp=%h", wcnt, 13'd0); end
      checks++;
      if (out_done !== 1'b0) begin errors++; $display("FAIL reset_out_done got=%b exp=0", out_done); end
      checks++;
      if (bus.dst_data !== 32'h0) begin errors++; $display("FAIL reset_dst_data got=%h exp=0", bus.dst_data); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      bus.outr = 1'b1; bus.oa = 12'h005; bus.ra = 4'd2;
      tick();
      bus.outr = 1'b0; bus.od_data = 32'h0000_1234;
      tick();
      bus.dst_v = 1'b1; bus.dst_a = 12'h005;
      tick();
      bus.dst_v = 1'b0;
      checks++;
      if (bus.dst_data !== 32'h0000_1234) begin errors++; $display("FAIL basic_read got=%h exp=%h", bus.dst_data, 32'h0000_1234); end
      checks++;
      if (wcnt !== 13'd1) begin errors++; $display("FAIL basic_wcnt got=%0d exp=1", wcnt); end
   endtask

   task automatic test_relu;
`ifdef OUT_RELU_EN
      relu_exp = 32'h0000_0000;
`else
      relu_exp = 32'hFFFF_FFF0;
`endif
      bus.outr = 1'b1; bus.oa = 12'h010;
      tick();
      bus.outr = 1'b0; bus.od_data = 32'hFFFF_FFF0;
      tick();
      bus.dst_v = 1'b1; bus.dst_a = 12'h010;
      tick();
      bus.dst_v = 1'b0;
      checks++;
      if (bus.dst_data !== relu_exp) begin errors++; $display("FAIL relu_read got=%h exp=%h", bus.dst_data, relu_exp); end
   endtask

   task automatic test_bypass;
      bus.outr = 1'b1; bus.oa = 12'h020;
      tick();
      bus.outr = 1'b0; bus.od_data = 32'h1111_1111;
      tick();
      bus.outr = 1'b1; bus.oa = 12'h020;
      tick();
      bus.outr = 1'b0; bus.od_data = 32'hAAAA_0001;
      bus.dst_v = 1'b1; bus.dst_a = 12'h020;
      tick();
      bus.dst_v = 1'b0;
      checks++;
      if (bus.dst_data !== 32'hAAAA_0001) begin errors++; $display("FAIL bypass_read got=%h exp=%h", bus.dst_data, 32'hAAAA_0001); end
      bus.od_data = 32'h0;
      tick();
      bus.dst_v = 1'b1;
      tick();
      bus.dst_v = 1'b0;
      checks++;
      if (bus.dst_data !== 32'hAAAA_0001) begin errors++; $display("FAIL bypass_reread got=%h exp=%h", bus.dst_data, 32'hAAAA_0001); end
   endtask

   task automatic test_sinit_write;
      bus.outr = 1'b1; bus.oa = 12'h030;
      tick();
      bus.outr = 1'b0; bus.od_data = 32'h5; s_init = 1'b1;
      tick();
      s_init = 1'b0;
      checks++;
      if (wcnt !== 13'd1) begin errors++; $display("FAIL sinit_write_wcnt got=%0d exp=1", wcnt); end
   endtask

   task automatic test_back_to_back;
      s_init = 1'b1;
      tick();
      s_init = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.outr = 1'b1; bus.oa = 12'(i); bus.od_data = 32'(32'h100 + i - 1);
         tick();
      end
      bus.outr = 1'b0; bus.od_data = 32'h10F; bus.update = 1'b1;
      tick();
      bus.update = 1'b0;
      checks++;
      if (out_done !== 1'b0) begin errors++; $display("FAIL done_early got=%b exp=0", out_done); end
      checks++;
      if (wcnt !== 13'd16) begin errors++; $display("FAIL b2b_wcnt got=%0d exp=16", wcnt); end
      tick();
      checks++;
      if (out_done !== 1'b1) begin errors++; $display("FAIL done_rise got=%b exp=1", out_done); end
      bus.dst_v = 1'b1; bus.dst_a = 12'h007;
      tick();
      bus.dst_v = 1'b0;
      checks++;
      if (out_done !== 1'b0) begin errors++; $display("FAIL done_fall got=%b exp=0", out_done); end
      checks++;
      if (bus.dst_data !== 32'h107) begin errors++; $display("FAIL b2b_read got=%h exp=%h", bus.dst_data, 32'h107); end
   endtask

   task automatic test_hold;
      bus.dst_v = 1'b1; bus.dst_a = 12'h003;
      tick();
      bus.dst_v = 1'b0; bus.dst_ready = 1'b0;
      checks++;
      if (bus.dst_data !== 32'h103) begin errors++; $display("FAIL hold_first got=%h exp=%h", bus.dst_data, 32'h103); end
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin bus.outr = 1'b1; bus.oa = 12'h003; end
         if (k == 1) begin bus.outr = 1'b0; bus.od_data = 32'h7EAD_BEEF; end
         tick();
         checks++;
         if (bus.dst_data !== 32'h103) begin errors++; $display("FAIL hold_cycle%0d got=%h exp=%h", k, bus.dst_data, 32'h103); end
      end
      bus.dst_ready = 1'b1;
   endtask

   task automatic test_sinit_update;
      bus.update = 1'b1; s_init = 1'b1;
      tick();
      bus.update = 1'b0; s_init = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_done !== 1'b0) begin errors++; $display("FAIL sinit_update_c%0d got=%b exp=0", k, out_done); end
         tick();
      end
   endtask

   task automatic test_saturation;
      s_init = 1'b1;
      tick();
      s_init = 1'b0;
      for (int i = 0; i <= 4096; i++) begin
         bus.outr = 1'b1; bus.oa = 12'(i); bus.od_data = 32'(i - 1);
         tick();
      end
      bus.outr = 1'b0; bus.od_data = 32'd4096;
      tick();
      checks++;
      if (wcnt !== 13'h1000) begin errors++; $display("FAIL wcnt_saturate got=%h exp=%h", wcnt, 13'h1000); end
   endtask

   task automatic test_async_reset;
      bus.update = 1'b1;
      tick();
      bus.update = 1'b0;
      tick();
      checks++;
      if (out_done !== 1'b1) begin errors++; $display("FAIL pre_reset_done got=%b exp=1", out_done); end
      bus.outr = 1'b1; bus.oa = 12'h050; bus.od_data = 32'h55;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (wcnt !== 13'd0) begin errors++; $display("FAIL async_wcnt got=%h exp=0", wcnt); end
      checks++;
      if (out_done !== 1'b0) begin errors++; $display("FAIL async_out_done got=%b exp=0", out_done); end
      checks++;
      if (bus.dst_data !== 32'h0) begin errors++; $display("FAIL async_dst_data got=%h exp=0", bus.dst_data); end
      @(negedge clk);
      rst_n = 1'b1; bus.outr = 1'b0;
      tick();
      checks++;
      if (wcnt !== 13'd0) begin errors++; $display("FAIL dropped_w0 got=%0d exp=0", wcnt); end
      bus.dst_v = 1'b1; bus.dst_a = 12'h123;
      tick();
      bus.dst_v = 1'b0;
      checks++;
      if (bus.dst_data !== 32'h123) begin errors++; $display("FAIL mem_kept got=%h exp=%h", bus.dst_data, 32'h123); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      s_init = 1'b0;
      bus.outr = 1'b0;
      bus.ra = '0;
      bus.oa = '0;
      bus.update = 1'b0;
      bus.od_data = '0;
      bus.dst_v = 1'b0;
      bus.dst_a = '0;
      bus.dst_ready = 1'b1;
      test_reset();
      test_basic();
      test_relu();
      test_bypass();
      test_sinit_write();
      test_back_to_back();
      test_hold();
      test_sinit_update();
      test_saturation();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
